// File: rtl/pv2byp_muldiv_issue_unit.sv
// pv2byp_muldiv_issue_unit
// Core-side initiator for the pipelined multiply/divide unit. Issues M-extension
// operations as val/rdy requests and remembers, in order, which destination and
// which half of the 64-bit response each outstanding operation needs. Responses
// are reduced to 32 bits and presented on a single registered writeback stage.
module pv2byp_muldiv_issue_unit #(
    parameter int DEPTH = 4,
    parameter int DESTW = 5
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       op_val,
    output logic                       op_rdy,
    input  logic [2:0]                 op_code,
    input  logic [31:0]                op_a,
    input  logic [31:0]                op_b,
    input  logic [DESTW-1:0]           op_dest,

    output logic                       muldivreq_val,
    input  logic                       muldivreq_rdy,
    output logic [2:0]                 muldivreq_msg_fn,
    output logic [31:0]                muldivreq_msg_a,
    output logic [31:0]                muldivreq_msg_b,

    input  logic                       muldivresp_val,
    output logic                       muldivresp_rdy,
    input  logic [63:0]                muldivresp_msg_result,

    output logic                       wb_val,
    input  logic                       wb_rdy,
    output logic [DESTW-1:0]           wb_dest,
    output logic [31:0]                wb_data,

    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic                       err
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

    // Core-side operation encodings; 6 and 7 fall through to MUL.
    typedef enum logic [2:0] {
        OP_MUL  = 3'd0,
        OP_MULH = 3'd1,
        OP_DIV  = 3'd2,
        OP_DIVU = 3'd3,
        OP_REM  = 3'd4,
        OP_REMU = 3'd5
    } op_code_e;

    // Responder function encodings.
    typedef enum logic [2:0] {
        FN_MUL  = 3'd0,
        FN_DIV  = 3'd1,
        FN_DIVU = 3'd2,
        FN_REM  = 3'd3,
        FN_REMU = 3'd4
    } fn_e;

    logic [DESTW-1:0] tag_dest [DEPTH];
    logic             tag_hi   [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;

    logic full;
    logic push;
    logic resp_fire;
    logic pop;
    logic stray;
    logic op_sel_hi;
    fn_e  op_fn;

    // Issue handshake: the op and the request fire together, gated by the registered count.
    always_comb begin
        full             = (inflight == FULL_COUNT);
        muldivreq_val    = op_val && !full;
        op_rdy           = muldivreq_rdy && !full;
        push             = op_val && op_rdy;
        muldivreq_msg_a  = op_a;
        muldivreq_msg_b  = op_b;
        muldivreq_msg_fn = op_fn;
    end

    // Translate the core opcode into a responder function and pick the result half.
    always_comb begin
        op_fn     = FN_MUL;
        op_sel_hi = 1'b0;
        case (op_code)
            OP_MULH: begin op_fn = FN_MUL;  op_sel_hi = 1'b1; end
            OP_DIV:  begin op_fn = FN_DIV;  op_sel_hi = 1'b0; end
            OP_DIVU: begin op_fn = FN_DIVU; op_sel_hi = 1'b0; end
            OP_REM:  begin op_fn = FN_REM;  op_sel_hi = 1'b1; end
            OP_REMU: begin op_fn = FN_REMU; op_sel_hi = 1'b1; end
            default: begin op_fn = FN_MUL;  op_sel_hi = 1'b0; end
        endcase
    end

    // Response acceptance: one writeback register, free when empty or draining this cycle.
    always_comb begin
        muldivresp_rdy = !wb_val || wb_rdy;
        resp_fire      = muldivresp_val && muldivresp_rdy;
        pop            = resp_fire && (inflight != '0);
        stray          = resp_fire && (inflight == '0);
    end

    // Tag storage needs no reset; entries are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_dest[wr_ptr] <= op_dest;
            tag_hi[wr_ptr]   <= op_sel_hi;
        end
    end

    // Circular pointers advance on push/pop and wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
        end
    end

    // Outstanding count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else if (push && !pop) begin
            inflight <= inflight + CNTW'(1);
        end else if (pop && !push) begin
            inflight <= inflight - CNTW'(1);
        end
    end

    // Writeback register loads the selected half of a matched response, else drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_val  <= 1'b0;
            wb_dest <= '0;
            wb_data <= '0;
        end else if (pop) begin
            wb_val  <= 1'b1;
            wb_dest <= tag_dest[rd_ptr];
            wb_data <= tag_hi[rd_ptr] ? muldivresp_msg_result[63:32]
                                      : muldivresp_msg_result[31:0];
        end else if (wb_val && wb_rdy) begin
            wb_val  <= 1'b0;
        end
    end

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (stray) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/pv2byp_muldiv_issue_unit.md
# pv2byp_muldiv_issue_unit

Core-side initiator for the pipelined multiply/divide unit. It accepts 32-bit M-extension operations from the X stage, issues val/rdy requests to the muldiv responder, and tracks up to DEPTH in-flight operations in order. Each 64-bit response is reduced to the correct 32-bit field and returned with its destination register on a registered writeback port feeding the W-stage mux.

## Interface

Parameters:
- DEPTH, 4, maximum outstanding requests; power of two, 2..16.
- DESTW, 5, destination register specifier width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- op_val  in  1  operation valid.
- op_rdy  out  1  operation accepted when op_val && op_rdy.
- op_code  in  3  0 MUL, 1 MULH, 2 DIV, 3 DIVU, 4 REM, 5 REMU; 6 and 7 are treated as MUL.
- op_a, op_b  in  32 each  operands.
- op_dest  in  DESTW  destination register.
- muldivreq_val  out  1  request valid.
- muldivreq_rdy  in  1  responder ready.
- muldivreq_msg_fn  out  3  0 mul, 1 div, 2 divu, 3 rem, 4 remu.
- muldivreq_msg_a, muldivreq_msg_b  out  32 each  operands, passed through unchanged.
- muldivresp_val  in  1  response valid.
- muldivresp_rdy  out  1  response accepted when muldivresp_val && muldivresp_rdy.
- muldivresp_msg_result  in  64  mul: signed product {hi,lo}; div/divu/rem/remu: {remainder, quotient}.
- wb_val  out  1  writeback valid (registered).
- wb_rdy  in  1  writeback consumer ready.
- wb_dest  out  DESTW  destination register.
- wb_data  out  32  selected result word.
- inflight  out  $clog2(DEPTH+1)  outstanding count.
- err  out  1  sticky protocol error.

## Operation

Issue path (combinational):
- full = (inflight == DEPTH).
- muldivreq_val = op_val && !full.
- op_rdy = muldivreq_rdy && !full.
- The op fires if and only if the request fires.
- fn mapping: MUL and MULH -> 0; DIV -> 1; DIVU -> 2; REM -> 3; REMU -> 4.

Tag FIFO:
- Circular buffer of DEPTH entries, each {dest, sel_hi}.
- sel_hi = 1 for MULH, REM and REMU; 0 otherwise.
- Push on request fire; pop on response fire.
- Pointers wrap modulo DEPTH.

inflight counter:
- +1 on push only, -1 on pop only, unchanged on both.
- A pop in the same cycle does not free a slot for a push while full; op_rdy uses the registered count.

Response path:
- muldivresp_rdy = !wb_val || wb_rdy. This is a single pipeline register with no skid.
- On response fire with inflight > 0:
  - wb_val <= 1;
  - wb_dest <= head.dest;
  - wb_data <= head.sel_hi ? result[63:32] : result[31:0].
- On wb_val && wb_rdy with no new response fire: wb_val <= 0.
- Response fire with inflight == 0 is a protocol violation:
  - the response is consumed and dropped;
  - wb and the pointers are unchanged;
  - err <= 1.
- err clears only on reset.

Reset (reset == 0, asynchronous):
- Clears inflight, both pointers, wb_val, wb_dest, wb_data and err to 0.
- Mid-operation reset discards all outstanding tags. Responses for discarded tags that arrive after reset set err.

## Timing

- Issue latency 0: request driven the same cycle as op_val.
- Writeback latency 1: response accepted at edge N -> wb_val high after edge N.
- Throughput: 1 op/cycle issue and 1 writeback/cycle when wb_rdy is held high.
- Response order is assumed equal to request order, since the muldiv pipeline is in-order. No reordering is performed.
- No output depends combinationally on muldivresp_val.
- op_rdy and muldivreq_val depend combinationally on muldivreq_rdy and op_val respectively.

## Test plan

- MUL then MULH with a=0xdeadbeef, b=0x10000000:
  - requests carry fn=0 both times;
  - responder returns 0xfdeadbee_f0000000;
  - wb_data = 0xf0000000, then 0xfdeadbee;
  - wb_dest matches each op.
- DIV / REM / DIVU / REMU:
  - REM 0x222,0x32 -> fn=3, wb_data 0x0000002e.
  - DIV 0x222,0x2a -> fn=1, wb_data 0x0000000d.
  - DIVU 0xdeadbeef,0x0000beef -> fn=2, wb_data 0x00012a90.
  - REMU same operands -> fn=4, wb_data 0x0000227f.
- Fill with DEPTH=4 and the responder never returning:
  - 4 ops accepted, inflight=4;
  - 5th op sees op_rdy=0 and muldivreq_val=0.
  - Return 1 response -> inflight=3 next cycle, then the 5th op is accepted.
  - Pointer wrap is checked over 12 back-to-back ops.
- Backpressure: wb_rdy=0 with wb_val=1.
  - muldivresp_rdy=0, response held, wb_data stable.
  - Release wb_rdy -> the held response is accepted in the same cycle, wb_val stays 1 with new data.
- Random delays on source, responder and wb consumer, 100 mixed ops:
  - all results and dests match the golden model in order;
  - final inflight=0, err=0.
- Reset and errors:
  - reset=0 with 2 ops in flight -> inflight=0, wb_val=0 asynchronously.
  - A subsequent stray response -> err=1 and no wb_val.
